// File: rtl/ahb_lite_des_master.sv
// AHB-Lite master that loads keys/data into a memory-mapped DES slave, polls, reads the result.
// Build option: DES_MASTER_KEY_CACHE_EN skips the key writes when keys repeat a finished run.
module ahb_lite_des_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          POLL_LIMIT = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        encr_decr,
    input  logic [63:0] data_in,
    input  logic [63:0] key1_in,
    input  logic [63:0] key2_in,
    input  logic [63:0] key3_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] result,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [63:0] HWDATA
);
    typedef enum logic [3:0] {
        IDLE, WKEY1, WKEY2, WKEY3, WDATA, WCTRL, POLL, RDRES, FINISH, FAULT
    } state_t;

    localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

    state_t      r_state, w_next;
    logic [63:0] r_key1, r_key2, r_key3, r_data, r_result, r_hwdata;
    logic        r_encr, r_dp_valid, r_dp_rd;
    logic [7:0]  r_poll_cnt;
    logic        w_cap, w_hit, w_err, w_rd_done, w_nonseq, w_acc, w_rd_pend;
    logic [7:0]  w_off;
    logic [63:0] w_wdata;

    assign w_cap     = start & (r_state inside {IDLE, FINISH, FAULT});
    assign w_err     = r_dp_valid & HRESP;
    assign w_rd_pend = r_dp_valid & r_dp_rd;
    assign w_rd_done = w_rd_pend & HREADY;
    assign w_acc     = w_nonseq & HREADY;

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH);
    assign error     = (r_state == FAULT);
    assign result    = r_result;
    assign HWDATA    = r_hwdata;
    assign HTRANS    = w_nonseq ? 2'b10 : 2'b00;
    assign HADDR     = w_nonseq ? BASE_ADDR + {24'd0, w_off} : 32'd0;
    assign HSIZE     = 3'b011;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

`ifdef DES_MASTER_KEY_CACHE_EN
    // r_key* still hold the previous run's keys until the next capture.
    logic r_cache_ok;
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET)                r_cache_ok <= 1'b0;
        else if (r_state == FINISH) r_cache_ok <= 1'b1;
        else if (r_state == FAULT)  r_cache_ok <= 1'b0;
    end
    assign w_hit = ((r_state == FINISH) | ((r_state == IDLE) & r_cache_ok))
                 & (key1_in == r_key1) & (key2_in == r_key2)
                 & (key3_in == r_key3);
`else
    assign w_hit = 1'b0;
`endif

    // Status/result reads wait for their own data phase before reissuing.
    always_comb begin
        w_nonseq = 1'b0;
        HWRITE   = 1'b0;
        w_off    = 8'h00;
        w_wdata  = r_hwdata;
        unique case (r_state)
            WKEY1: begin w_nonseq = 1'b1; HWRITE = 1'b1; w_off = 8'h00; w_wdata = r_key1; end
            WKEY2: begin w_nonseq = 1'b1; HWRITE = 1'b1; w_off = 8'h08; w_wdata = r_key2; end
            WKEY3: begin w_nonseq = 1'b1; HWRITE = 1'b1; w_off = 8'h10; w_wdata = r_key3; end
            WDATA: begin w_nonseq = 1'b1; HWRITE = 1'b1; w_off = 8'h18; w_wdata = r_data; end
            WCTRL: begin
                w_nonseq = 1'b1;
                HWRITE   = 1'b1;
                w_off    = 8'h20;
                w_wdata  = {62'd0, r_encr, 1'b1};
            end
            POLL:    begin w_nonseq = ~w_rd_pend; w_off = 8'h28; end
            RDRES:   begin w_nonseq = ~w_rd_pend; w_off = 8'h30; end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, FINISH, FAULT:
                w_next = w_cap ? (w_hit ? WDATA : WKEY1) : IDLE;
            WKEY1: if (w_err) w_next = FAULT; else if (HREADY) w_next = WKEY2;
            WKEY2: if (w_err) w_next = FAULT; else if (HREADY) w_next = WKEY3;
            WKEY3: if (w_err) w_next = FAULT; else if (HREADY) w_next = WDATA;
            WDATA: if (w_err) w_next = FAULT; else if (HREADY) w_next = WCTRL;
            WCTRL: if (w_err) w_next = FAULT; else if (HREADY) w_next = POLL;
            POLL: begin
                if (w_err)
                    w_next = FAULT;
                else if (w_rd_done) begin
                    if (HRDATA[0])             w_next = RDRES;
                    else if (r_poll_cnt >= LIMIT) w_next = FAULT;
                end
            end
            RDRES: if (w_err) w_next = FAULT; else if (w_rd_done) w_next = FINISH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state    <= IDLE;
            r_key1     <= '0;
            r_key2     <= '0;
            r_key3     <= '0;
            r_data     <= '0;
            r_encr     <= 1'b0;
            r_result   <= '0;
            r_hwdata   <= '0;
            r_dp_valid <= 1'b0;
            r_dp_rd    <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_key1     <= key1_in;
                r_key2     <= key2_in;
                r_key3     <= key3_in;
                r_data     <= data_in;
                r_encr     <= encr_decr;
                r_poll_cnt <= '0;
            end else if (w_acc && r_state == POLL) begin
                r_poll_cnt <= r_poll_cnt + 8'd1;
            end
            // An error response cancels the pending address phase.
            if (w_err) begin
                r_dp_valid <= 1'b0;
            end else if (HREADY) begin
                r_dp_valid <= w_nonseq;
                r_dp_rd    <= w_nonseq & ~HWRITE;
            end
            if (w_acc && HWRITE)
                r_hwdata <= w_wdata;
            if (r_state == RDRES && w_rd_done && !w_err)
                r_result <= HRDATA;
        end
    end
endmodule

// File: tb/tb_ahb_lite_des_master.sv
// Directed bench for ahb_lite_des_master with a behavioural AHB-Lite DES slave.
// Covers transfer order, wait states, error response, poll timeout, reset and key cache.
`timescale 1ns/1ps
module tb_ahb_lite_des_master;
    localparam logic [63:0] K1    = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2    = 64'h23456789ABCDEF01;
    localparam logic [63:0] K3    = 64'h456789ABCDEF0123;
    localparam logic [63:0] DIN   = 64'h4E6F772069732074;
    localparam logic [63:0] RES   = 64'h3FA40E8A984D4815;
    localparam logic [31:0] NOERR = 32'hFFFF_FFFF;
`ifdef DES_MASTER_KEY_CACHE_EN
    localparam logic [31:0] EXP_FIRST = 32'h18;
    localparam int          EXP_NWR   = 2;
`else
    localparam logic [31:0] EXP_FIRST = 32'h00;
    localparam int          EXP_NWR   = 5;
`endif

    logic        HCLK = 1'b0, HRESET = 1'b0;
    logic        start = 1'b0, encr_decr = 1'b0;
    logic [63:0] data_in = '0, key1_in = '0, key2_in = '0, key3_in = '0;
    logic        busy, done, error;
    logic [63:0] result;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic [63:0] HRDATA = '0;
    logic [31:0] HADDR;
    logic        HWRITE, HMASTLOCK;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA;

    ahb_lite_des_master #(.BASE_ADDR(32'h0), .POLL_LIMIT(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .encr_decr(encr_decr),
        .data_in(data_in), .key1_in(key1_in), .key2_in(key2_in),
        .key3_in(key3_in), .busy(busy), .done(done), .error(error),
        .result(result), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cfg_waits = 0, cfg_st = 3;
    logic [31:0] cfg_eaddr = NOERR;
    logic        dp_act = 0, dp_wr = 0, err_ph = 0, chk_idle = 0, p_hold = 0;
    logic [31:0] dp_addr = '0, p_addr = '0, first_addr = '0;
    logic [63:0] p_wdata = '0;
    int          wcnt = 0, n_wr = 0, n_st = 0, n_done = 0, n_err = 0, n_acc = 0;
    logic [31:0] wr_addr [16];
    logic [63:0] wr_data [16];

    // Slave: sample and respond mid-cycle, away from the DUT's rising edge.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            dp_act = 0; err_ph = 0; chk_idle = 0; p_hold = 0;
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (done)  n_done++;
            if (error) n_err++;
            if (chk_idle) begin
                check("htrans_after_err", 64'(HTRANS), 64'd0);
                chk_idle = 0;
            end
            if (p_hold) begin
                check("haddr_hold", 64'(HADDR), 64'(p_addr));
                check("htrans_hold", 64'(HTRANS), 64'd2);
                if (dp_act && dp_wr) check("hwdata_hold", HWDATA, p_wdata);
            end
            if (err_ph) begin
                HREADY = 1'b1; HRESP = 1'b1; err_ph = 0; dp_act = 0;
            end else if (dp_act && wcnt > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; wcnt--;
            end else if (dp_act && dp_addr == cfg_eaddr) begin
                HREADY = 1'b0; HRESP = 1'b1; err_ph = 1; chk_idle = 1;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                if (dp_act) begin
                    if (dp_wr) begin
                        if (n_wr < 16) begin
                            wr_addr[n_wr] = dp_addr;
                            wr_data[n_wr] = HWDATA;
                        end
                        n_wr++;
                    end else if (dp_addr == 32'h28) begin
                        n_st++;
                        HRDATA = {63'd0, n_st == cfg_st};
                    end else if (dp_addr == 32'h30) begin
                        HRDATA = RES;
                    end
                end
                dp_act = 0;
                if (HTRANS == 2'b10) begin
                    dp_act = 1; dp_addr = HADDR; dp_wr = HWRITE; wcnt = cfg_waits;
                    if (n_acc == 0) first_addr = HADDR;
                    n_acc++;
                end
            end
            p_hold  = !HREADY && !HRESP && HTRANS == 2'b10;
            p_addr  = HADDR;
            p_wdata = HWDATA;
        end
    end

    task automatic launch(input logic alt, input logic enc, input int waits,
                          input int st, input logic [31:0] eaddr);
        cfg_waits = waits; cfg_st = st; cfg_eaddr = eaddr;
        n_wr = 0; n_st = 0; n_done = 0; n_err = 0; n_acc = 0;
        key1_in = K1 ^ {64{alt}};
        key2_in = K2 ^ {64{alt}};
        key3_in = K3 ^ {64{alt}};
        data_in = DIN; encr_decr = enc; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic run(input logic alt, input logic enc, input int waits,
                       input int st, input logic [31:0] eaddr);
        int cyc;
        launch(alt, enc, waits, st, eaddr);
        cyc = 0;
        while (!(done || error) && cyc < 300) begin
            @(negedge HCLK);
            cyc++;
        end
        check("run_timeout", 64'(cyc >= 300), 64'd0);
        repeat (3) @(negedge HCLK);
    endtask

    task automatic check_seq(input string tag, input int n, input logic alt,
                             input logic enc);
        logic [63:0] exp;
        for (int i = 0; i < n; i++) begin
            case (i)
                0:       exp = K1 ^ {64{alt}};
                1:       exp = K2 ^ {64{alt}};
                2:       exp = K3 ^ {64{alt}};
                3:       exp = DIN;
                default: exp = {62'd0, enc, 1'b1};
            endcase
            check({tag, "_addr"}, 64'(wr_addr[i]), 64'(i * 8));
            check({tag, "_data"}, wr_data[i], exp);
        end
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge HCLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_htrans", 64'(HTRANS), 64'd0);
        check("rst_haddr", 64'(HADDR), 64'd0);
        check("hsize", 64'(HSIZE), 64'd3);
        check("hprot", 64'(HPROT), 64'd3);
        check("hburst_lock", 64'({HBURST, HMASTLOCK}), 64'd0);
        HRESET = 1'b1;
        @(negedge HCLK);

        run(1'b0, 1'b1, 0, 3, NOERR);
        check("t1_nwr", 64'(n_wr), 64'd5);
        check_seq("t1", 5, 1'b0, 1'b1);
        check("t1_nstatus", 64'(n_st), 64'd3);
        check("t1_result", result, RES);
        check("t1_done", 64'(n_done), 64'd1);
        check("t1_err", 64'(n_err), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        run(1'b1, 1'b0, 2, 3, NOERR);
        check("t2_nwr", 64'(n_wr), 64'd5);
        check_seq("t2", 5, 1'b1, 1'b0);
        check("t2_nstatus", 64'(n_st), 64'd3);
        check("t2_done", 64'(n_done), 64'd1);
        check("t2_result", result, RES);

        HRDATA = '0;
        run(1'b0, 1'b1, 0, 3, 32'h18);
        check("t3_nwr", 64'(n_wr), 64'd3);
        check_seq("t3", 3, 1'b0, 1'b1);
        check("t3_nacc", 64'(n_acc), 64'd4);
        check("t3_err", 64'(n_err), 64'd1);
        check("t3_done", 64'(n_done), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_result", result, RES);

        run(1'b0, 1'b1, 0, 0, NOERR);
        check("t4_nstatus", 64'(n_st), 64'd4);
        check("t4_err", 64'(n_err), 64'd1);
        check("t4_done", 64'(n_done), 64'd0);

        launch(1'b0, 1'b1, 0, 0, NOERR);
        cyc = 0;
        while (n_st < 1 && cyc < 100) begin
            @(negedge HCLK);
            cyc++;
        end
        check("t5_poll_timeout", 64'(cyc >= 100), 64'd0);
        check("t5_busy_pre", 64'(busy), 64'd1);
        #2 HRESET = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done_err", 64'({done, error}), 64'd0);
        check("t5_result", result, 64'd0);
        check("t5_htrans", 64'(HTRANS), 64'd0);
        check("t5_haddr", 64'(HADDR), 64'd0);
        check("t5_hwrite", 64'(HWRITE), 64'd0);
        check("t5_hwdata", HWDATA, 64'd0);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        run(1'b0, 1'b1, 0, 3, NOERR);
        check("t5_first", 64'(first_addr), 64'd0);
        check("t5_nwr", 64'(n_wr), 64'd5);
        check("t5_done", 64'(n_done), 64'd1);

        run(1'b0, 1'b1, 0, 3, NOERR);
        check("t6_first", 64'(first_addr), 64'(EXP_FIRST));
        check("t6_nwr", 64'(n_wr), 64'(EXP_NWR));
        check("t6_done", 64'(n_done), 64'd1);
        check("t6_result", result, RES);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
